// File: rtl/lincomb_rr_sequencer.sv
// Round-robin sharing of one R = 3A - 9B slave between two requesters; writes A then B, captures R.
// Latency: accept edge E0 -> response strobe during E4-E5; backpressure: ready only in IDLE, one transaction in flight.
module lincomb_rr_sequencer #(
    parameter int N = 32
) (
    input  logic         csi_clk,
    input  logic         rsi_srst,
    input  logic         coe_req0_valid,
    input  logic [N-1:0] coe_req0_a,
    input  logic [N-1:0] coe_req0_b,
    output logic         coe_req0_ready,
    input  logic         coe_req1_valid,
    input  logic [N-1:0] coe_req1_a,
    input  logic [N-1:0] coe_req1_b,
    output logic         coe_req1_ready,
    output logic [7:0]   avm_m0_address,
    output logic         avm_m0_write,
    output logic [N-1:0] avm_m0_writedata,
    input  logic [N-1:0] coe_r_in,
    output logic         coe_rsp_valid,
    output logic         coe_rsp_id,
    output logic [N-1:0] coe_rsp_data
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_WR_A = 3'd1;
    localparam logic [2:0] S_WR_B = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_CAP  = 3'd4;

    logic [2:0]   state_q, state_d;
    logic         ptr_q, ptr_d;
    logic         id_q, id_d;
    logic [N-1:0] a_q, a_d;
    logic [N-1:0] b_q, b_d;
    logic         rsp_valid_q, rsp_valid_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_data_q, rsp_data_d;

    logic is_idle;
    logic grant0;
    logic grant1;

    // Readies are gated by reset so nothing is ever reported accepted on a reset edge.
    always_comb begin
        is_idle = (state_q == S_IDLE) && !rsi_srst;
        grant0  = is_idle && coe_req0_valid && (!coe_req1_valid || !ptr_q);
        grant1  = is_idle && coe_req1_valid && (!coe_req0_valid ||  ptr_q);
    end

    assign coe_req0_ready = grant0;
    assign coe_req1_ready = grant1;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_valid_d = 1'b0;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        case (state_q)
            S_IDLE: begin
                if (grant0 || grant1) begin
                    id_d    = grant1;
                    a_d     = grant1 ? coe_req1_a : coe_req0_a;
                    b_d     = grant1 ? coe_req1_b : coe_req0_b;
                    ptr_d   = !grant1;
                    state_d = S_WR_A;
                end
            end
            S_WR_A: state_d = S_WR_B;
            S_WR_B: state_d = S_WAIT;
            S_WAIT: state_d = S_CAP;
            S_CAP: begin
                rsp_valid_d = 1'b1;
                rsp_id_d    = id_q;
                rsp_data_d  = coe_r_in;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_m0_write     = 1'b0;
        avm_m0_address   = 8'd0;
        avm_m0_writedata = '0;
        if (state_q == S_WR_A) begin
            avm_m0_write     = 1'b1;
            avm_m0_writedata = a_q;
        end else if (state_q == S_WR_B) begin
            avm_m0_write     = 1'b1;
            avm_m0_address   = 8'd1;
            avm_m0_writedata = b_q;
        end
    end

    always_ff @(posedge csi_clk) begin
        if (rsi_srst) begin
            state_q     <= S_IDLE;
            ptr_q       <= 1'b0;
            id_q        <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign coe_rsp_valid = rsp_valid_q;
    assign coe_rsp_id    = rsp_id_q;
    assign coe_rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_lincomb_rr_sequencer.sv
// Directed bench for lincomb_rr_sequencer with a behavioural R = 3A - 9B slave attached.
module tb_lincomb_rr_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        v0, v1;
    logic [31:0] a0, b0, a1, b1;
    logic        rdy0, rdy1;
    logic [7:0]  addr;
    logic        wr;
    logic [31:0] wd;
    logic [31:0] r_in;
    logic        rsp_vld;
    logic        rsp_id;
    logic [31:0] rsp_data;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lincomb_rr_sequencer #(.N(32)) dut (
        .csi_clk          (clk),
        .rsi_srst         (rst),
        .coe_req0_valid   (v0),
        .coe_req0_a       (a0),
        .coe_req0_b       (b0),
        .coe_req0_ready   (rdy0),
        .coe_req1_valid   (v1),
        .coe_req1_a       (a1),
        .coe_req1_b       (b1),
        .coe_req1_ready   (rdy1),
        .avm_m0_address   (addr),
        .avm_m0_write     (wr),
        .avm_m0_writedata (wd),
        .coe_r_in         (r_in),
        .coe_rsp_valid    (rsp_vld),
        .coe_rsp_id       (rsp_id),
        .coe_rsp_data     (rsp_data)
    );

    // Compute slave: registered A/B, registered R recomputed every edge.
    logic [31:0] sl_a, sl_b;
    always_ff @(posedge clk) begin
        if (rst) begin
            sl_a <= '0;
            sl_b <= '0;
            r_in <= '0;
        end else begin
            if (wr && addr == 8'd0) sl_a <= wd;
            if (wr && addr == 8'd1) sl_b <= wd;
            r_in <= 32'd3 * sl_a - 32'd9 * sl_b;
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b,
                         output logic ok, output logic [31:0] data, output logic rid, output int lat);
        int n;
        ok = 1'b0; data = '0; rid = 1'b0; lat = 0;
        if (id) begin v1 = 1'b1; a1 = a; b1 = b; end
        else    begin v0 = 1'b1; a0 = a; b0 = b; end
        #1;
        n = 0;
        while (!(id ? rdy1 : rdy0) && n < 20) begin
            cyc_step(); #1; n++;
        end
        if (!(id ? rdy1 : rdy0)) begin
            v0 = 1'b0; v1 = 1'b0;
            return;
        end
        cyc_step();
        v0 = 1'b0; v1 = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            cyc_step();
            if (rsp_vld) begin
                ok = 1'b1; data = rsp_data; rid = rsp_id; lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v0 = 1'b1; a0 = 32'd5; b0 = 32'd6;
        v1 = 1'b1; a1 = 32'd7; b1 = 32'd8;
        cyc_step(); cyc_step(); #1;
        checks++; if ({rdy0, rdy1} !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", {rdy0, rdy1}); end
        checks++; if (wr !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", wr); end
        checks++; if (addr !== 8'd0 || wd !== 32'd0) begin errors++; $display("FAIL reset_bus: got addr %h data %h expected 0/0", addr, wd); end
        checks++; if (rsp_vld !== 1'b0 || rsp_id !== 1'b0) begin errors++; $display("FAIL reset_rsp: got vld %b id %b expected 0/0", rsp_vld, rsp_id); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h expected 0", rsp_data); end
        v0 = 1'b0; v1 = 1'b0;
        rst = 1'b0;
        cyc_step();
    endtask

    task automatic test_single();
        v0 = 1'b1; a0 = 32'd10; b0 = 32'd1;
        #1;
        checks++; if ({rdy0, rdy1} !== 2'b10) begin errors++; $display("FAIL single_ready: got %b expected 10", {rdy0, rdy1}); end
        cyc_step();
        v0 = 1'b0; a0 = 32'hDEAD; b0 = 32'hBEEF;
        checks++; if ({wr, addr, wd} !== {1'b1, 8'd0, 32'd10}) begin errors++; $display("FAIL single_wr_a: got %b/%h/%h expected 1/00/0000000a", wr, addr, wd); end
        checks++; if (rdy0 !== 1'b0) begin errors++; $display("FAIL single_ready_busy: got %b expected 0", rdy0); end
        cyc_step();
        checks++; if ({wr, addr, wd} !== {1'b1, 8'd1, 32'd1}) begin errors++; $display("FAIL single_wr_b: got %b/%h/%h expected 1/01/00000001", wr, addr, wd); end
        cyc_step();
        checks++; if ({wr, addr, wd} !== {1'b0, 8'd0, 32'd0}) begin errors++; $display("FAIL single_wait_bus: got %b/%h/%h expected 0/00/0", wr, addr, wd); end
        cyc_step();
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %b expected 0", rsp_vld); end
        cyc_step();
        checks++; if ({rsp_vld, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd21}) begin errors++; $display("FAIL single_rsp: got %b/%b/%h expected 1/0/00000015", rsp_vld, rsp_id, rsp_data); end
        cyc_step();
        checks++; if ({rsp_vld, rsp_data} !== {1'b0, 32'd21}) begin errors++; $display("FAIL single_rsp_hold: got %b/%h expected 0/00000015", rsp_vld, rsp_data); end
    endtask

    task automatic test_wrap();
        logic ok, rid;
        logic [31:0] data;
        int lat;
        issue(1'b1, 32'd0, 32'd1, ok, data, rid, lat);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL wrap_neg_timeout: got %b expected 1", ok); end
        checks++; if (data !== 32'hFFFFFFF7 || rid !== 1'b1) begin errors++; $display("FAIL wrap_neg: got %h id %b expected fffffff7 id 1", data, rid); end
        checks++; if (lat != 4) begin errors++; $display("FAIL wrap_latency: got %0d expected 4", lat); end
        issue(1'b0, 32'h80000000, 32'd0, ok, data, rid, lat);
        checks++; if (ok !== 1'b1 || data !== 32'h80000000 || rid !== 1'b0) begin errors++; $display("FAIL wrap_msb: got ok %b %h id %b expected 1 80000000 id 0", ok, data, rid); end
    endtask

    task automatic test_contention();
        int gseq[$], gstep[$], rstep[$], rids[$];
        logic [31:0] rdat[$];
        rst = 1'b1;
        v0 = 1'b1; a0 = 32'd1; b0 = 32'd0;
        v1 = 1'b1; a1 = 32'd0; b1 = 32'd1;
        cyc_step(); cyc_step();
        rst = 1'b0;
        #1;
        for (int s = 0; s < 80 && rdat.size() < 6; s++) begin
            if (rdy0 && rdy1) begin
                checks++; errors++;
                $display("FAIL contention_both_ready: got 11 expected one-hot at step %0d", s);
            end
            if (rdy0) begin gseq.push_back(0); gstep.push_back(s); end
            if (rdy1) begin gseq.push_back(1); gstep.push_back(s); end
            if (rsp_vld) begin rdat.push_back(rsp_data); rids.push_back(int'(rsp_id)); rstep.push_back(s); end
            cyc_step(); #1;
        end
        v0 = 1'b0; v1 = 1'b0;
        checks++;
        if (gseq.size() < 6 || rdat.size() < 6) begin
            errors++;
            $display("FAIL contention_count: got %0d grants %0d rsps expected 6/6", gseq.size(), rdat.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++; if (gseq[i] != i % 2) begin errors++; $display("FAIL contention_grant%0d: got %0d expected %0d", i, gseq[i], i % 2); end
                checks++;
                if (rdat[i] !== ((i % 2) ? 32'hFFFFFFF7 : 32'd3) || rids[i] != i % 2) begin
                    errors++;
                    $display("FAIL contention_rsp%0d: got %h id %0d expected %h id %0d", i, rdat[i], rids[i], (i % 2) ? 32'hFFFFFFF7 : 32'd3, i % 2);
                end
            end
            for (int i = 0; i < 5; i++) begin
                checks++; if (gstep[i + 1] - gstep[i] != 5) begin errors++; $display("FAIL contention_spacing%0d: got %0d expected 5", i, gstep[i + 1] - gstep[i]); end
            end
            checks++; if (gstep[1] != rstep[0]) begin errors++; $display("FAIL contention_overlap: got accept step %0d expected rsp step %0d", gstep[1], rstep[0]); end
        end
        repeat (8) cyc_step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] pa [4];
        logic [31:0] pb [4];
        logic [31:0] pexp [4];
        logic [31:0] rdat[$];
        int acc[$];
        int idx, wcount;
        pa = '{32'd5, 32'd7, 32'd100, 32'd2};
        pb = '{32'd0, 32'd2, 32'd10, 32'd1};
        pexp = '{32'd15, 32'd3, 32'd210, 32'hFFFFFFFD};
        idx = 0; wcount = 0;
        v0 = 1'b1; a0 = pa[0]; b0 = pb[0];
        #1;
        for (int s = 0; s < 60 && rdat.size() < 4; s++) begin
            logic took;
            took = rdy0;
            if (rdy0) begin
                acc.push_back(s);
                checks++; if (wr !== 1'b0) begin errors++; $display("FAIL b2b_write_at_accept: got %b expected 0", wr); end
            end
            if (rsp_vld) rdat.push_back(rsp_data);
            if (wr) wcount++;
            cyc_step();
            if (took) begin
                idx++;
                if (idx < 4) begin a0 = pa[idx]; b0 = pb[idx]; end
                else begin v0 = 1'b0; a0 = 32'hFFFF; b0 = 32'hFFFF; end
            end
            #1;
        end
        v0 = 1'b0;
        checks++;
        if (acc.size() != 4 || rdat.size() != 4) begin
            errors++;
            $display("FAIL b2b_count: got %0d accepts %0d rsps expected 4/4", acc.size(), rdat.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++; if (rdat[i] !== pexp[i]) begin errors++; $display("FAIL b2b_rsp%0d: got %h expected %h", i, rdat[i], pexp[i]); end
            end
            for (int i = 0; i < 3; i++) begin
                checks++; if (acc[i + 1] - acc[i] != 5) begin errors++; $display("FAIL b2b_spacing%0d: got %0d expected 5", i, acc[i + 1] - acc[i]); end
            end
        end
        checks++; if (wcount != 8) begin errors++; $display("FAIL b2b_write_cycles: got %0d expected 8", wcount); end
    endtask

    task automatic test_reset_mid();
        logic seen;
        logic ok;
        cyc_step();
        v0 = 1'b1; a0 = 32'd3; b0 = 32'd0;
        #1;
        checks++; if (rdy0 !== 1'b1) begin errors++; $display("FAIL rmid_accept: got %b expected 1", rdy0); end
        cyc_step();
        v0 = 1'b0;
        cyc_step();
        checks++; if ({wr, addr} !== {1'b1, 8'd1}) begin errors++; $display("FAIL rmid_in_wr_b: got %b/%h expected 1/01", wr, addr); end
        rst = 1'b1;
        cyc_step();
        rst = 1'b0;
        #1;
        checks++; if ({wr, rsp_vld, rdy0, rdy1} !== 4'b0000) begin errors++; $display("FAIL rmid_after: got wr/vld/rdy %b expected 0000", {wr, rsp_vld, rdy0, rdy1}); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL rmid_rsp_data: got %h expected 0", rsp_data); end
        seen = 1'b0;
        repeat (8) begin cyc_step(); if (rsp_vld) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_dropped_rsp: got %b expected 0", seen); end
        v0 = 1'b1; a0 = 32'd4; b0 = 32'd1;
        v1 = 1'b1; a1 = 32'd9; b1 = 32'd9;
        #1;
        checks++; if ({rdy0, rdy1} !== 2'b10) begin errors++; $display("FAIL rmid_pointer: got %b expected 10", {rdy0, rdy1}); end
        cyc_step();
        v0 = 1'b0; v1 = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 10 && !ok; k++) begin
            cyc_step();
            if (rsp_vld) ok = 1'b1;
        end
        checks++; if ({ok, rsp_id, rsp_data} !== {1'b1, 1'b0, 32'd3}) begin errors++; $display("FAIL rmid_fresh: got ok %b id %b %h expected 1 0 00000003", ok, rsp_id, rsp_data); end
        cyc_step();
    endtask

    task automatic test_idle_hold();
        for (int i = 0; i < 20; i++) begin
            cyc_step();
            checks++;
            if ({wr, rdy0, rdy1, rsp_vld, rsp_data} !== {4'b0000, 32'd3}) begin
                errors++;
                $display("FAIL idle_hold%0d: got wr/rdy/vld %b data %h expected 0000 00000003", i, {wr, rdy0, rdy1, rsp_vld}, rsp_data);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        v0 = 1'b0; v1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single();
        test_wrap();
        test_contention();
        test_back_to_back();
        test_reset_mid();
        test_idle_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lincomb_rr_sequencer.md
# lincomb_rr_sequencer

- Round-robin scheduler that shares one R = 3·A − 9·B compute slave between two requesters.
- Accepts an operand pair from a requester and drives it into the slave as two Avalon-MM writes: A to address 0, then B to address 1.
- Waits for the slave's registered result, then returns it to the requester, tagged with the requester's id.
- Sits between the requesters and the compute slave's avs_s0 write port and coe_R conduit. Only one transaction is in flight at a time.

## Interface

Parameters
- N, 32, operand/result width; must match the compute slave's N.

Ports
- csi_clk  in  1  single clock for everything.
- rsi_srst  in  1  reset, synchronous, active-high.
- coe_req0_valid  in  1  requester 0 has an operand pair.
- coe_req0_a  in  N  requester 0 operand A.
- coe_req0_b  in  N  requester 0 operand B.
- coe_req0_ready  out  1  requester 0 pair accepted at this edge.
- coe_req1_valid, coe_req1_a, coe_req1_b, coe_req1_ready  same as requester 0, for requester 1.
- avm_m0_address  out  8  slave address.
- avm_m0_write  out  1  slave write strobe.
- avm_m0_writedata  out  N  slave write data.
- coe_r_in  in  N  slave coe_R output.
- coe_rsp_valid  out  1  one-cycle result strobe.
- coe_rsp_id  out  1  requester that owns the result.
- coe_rsp_data  out  N  captured result.

## Operation

State machine: IDLE → WR_A → WR_B → WAIT → CAP → IDLE.

- IDLE
  - Arbitration is combinational; coe_reqX_ready is combinational from valid, state and pointer.
  - If only one requester is valid, it wins.
  - If both are valid, the requester selected by the round-robin pointer wins. The pointer resets to 0.
  - The winner's ready is high in this cycle only. At the edge, operands and id are latched, the pointer moves to the other requester, and state goes to WR_A.
  - With no valid requester, the block stays in IDLE and both readies stay 0.
- WR_A: avm_m0_write=1, address=0, writedata=latched A.
- WR_B: avm_m0_write=1, address=1, writedata=latched B.
- WAIT: write=0. The slave updates coe_R at this edge.
- CAP: coe_r_in now holds 3A−9B. At the edge:
  - coe_rsp_data ← coe_r_in;
  - coe_rsp_id ← latched id;
  - coe_rsp_valid ← 1;
  - state → IDLE.
- Outside WR_A/WR_B: write=0, address=0, writedata=0.
- Readies are 0 in every state except IDLE.
- Arithmetic: modulo 2^N, performed by the slave. The block passes data unchanged and does no overflow detection.
- Requester inputs are ignored except in the IDLE acceptance cycle. Operands are not re-sampled mid-transaction.

## Timing

- All state changes occur on the csi_clk rising edge.
- Reset: state=IDLE, pointer=0, coe_rsp_valid=0, coe_rsp_id=0, coe_rsp_data=0, avm_m0_write=0, address=0, writedata=0, readies=0.
- Reset has priority over every other action, including mid-transaction. The transaction in flight is dropped with no response. The slave shares rsi_srst and clears A/B.
- Latency: acceptance edge E0 → write A during cycle E0–E1 → write B during cycle E1–E2 → slave result at E3 → capture at E4. coe_rsp_valid is high for exactly the one cycle E4–E5.
- Throughput: one transaction per 5 cycles. The next acceptance can occur in the same cycle coe_rsp_valid is high, because the FSM is already in IDLE.
- coe_rsp_data and coe_rsp_id hold their value until the next capture.
- Simultaneous valids in IDLE: exactly one ready is asserted; the other waits. Under continuous requests the grants strictly alternate 0,1,0,1.
- A requester that drops valid before being accepted forfeits nothing; the pointer is unchanged.

## Test plan

- Single request: req0 A=10, B=1 → writes (0,10) then (1,1) on consecutive cycles; rsp_valid 4 cycles after accept; data=21; id=0.
- Wrap-around: req1 A=0, B=1 → data=0xFFFFFFF7 (−9 mod 2^32); id=1. Also A=0x80000000, B=0 → data=0x80000000.
- Contention: both valid from reset (req0 A=1,B=0; req1 A=0,B=1) → req0 granted first, rsp 3 id 0; req1 accepted in the cycle rsp_valid is high, rsp 0xFFFFFFF7 id 1; grants alternate over 6 back-to-back transactions.
- Back-to-back single requester: req0 held valid with changing operands → accept every 5 cycles; no write overlap; each result matches the pair sampled at acceptance.
- Reset mid-operation: assert rsi_srst during WR_B → next cycle write=0, rsp_valid=0, state IDLE, pointer=0; no response for the dropped pair; a fresh request completes normally.
- Idle hold: no valid for 20 cycles → write, readies and rsp_valid stay 0; rsp_data retains the last result.
